// File: rtl/mu0_pkg.sv
// MU0 control package: FSM state type, opcode constants, ALU op encodings,
// datapath mux-select constants and the bundled control-output struct shared
// by the decoder and the control top.
package mu0_pkg;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StExecute = 2'd1,
    StHalt    = 2'd2
  } state_e;

  // Opcodes, IR[15:12]. Values 8..15 decode as NOP.
  localparam logic [3:0] OpLda = 4'd0;
  localparam logic [3:0] OpSta = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpJmp = 4'd4;
  localparam logic [3:0] OpJge = 4'd5;
  localparam logic [3:0] OpJne = 4'd6;
  localparam logic [3:0] OpStp = 4'd7;

  // ALU operation select.
  localparam logic [1:0] MPassY = 2'b00;
  localparam logic [1:0] MAdd   = 2'b01;
  localparam logic [1:0] MInc   = 2'b10;
  localparam logic [1:0] MSub   = 2'b11;

  // Datapath mux selects.
  localparam logic XSelAcc   = 1'b0;
  localparam logic XSelPc    = 1'b1;
  localparam logic YSelData  = 1'b0;
  localparam logic YSelIr    = 1'b1;
  localparam logic AddrSelPc = 1'b0;
  localparam logic AddrSelIr = 1'b1;

  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic [1:0] m;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic       rd;
    logic       wr;
    logic       halted;
  } ctrl_t;

  // Opcodes LDA..SUB access memory and must wait for Mem_ready.
  function automatic logic is_mem_op(logic [3:0] f);
    return (f == OpLda) || (f == OpSta) || (f == OpAdd) || (f == OpSub);
  endfunction

endpackage

// File: rtl/mu0_decode.sv
// MU0 control decoder: purely combinational map from (state, opcode, flags,
// memory handshake) to datapath control signals.
//   state_i     : current FSM state
//   f_i         : opcode IR[15:12]
//   n_i, z_i    : accumulator negative / zero flags
//   mem_ready_i : memory completes the current access this cycle
//   ctrl_o      : mux selects, ALU op, register enables, strobes, halted
module mu0_decode
  import mu0_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] f_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        // Read instruction at PC while the ALU forms PC+1.
        ctrl_o.addr_sel = AddrSelPc;
        ctrl_o.rd       = 1'b1;
        ctrl_o.x_sel    = XSelPc;
        ctrl_o.m        = MInc;
        ctrl_o.ir_en    = mem_ready_i;
        ctrl_o.pc_en    = mem_ready_i;
      end
      StExecute: begin
        case (f_i)
          OpLda: begin
            ctrl_o.addr_sel = AddrSelIr;
            ctrl_o.rd       = 1'b1;
            ctrl_o.y_sel    = YSelData;
            ctrl_o.m        = MPassY;
            ctrl_o.acc_en   = mem_ready_i;
          end
          OpSta: begin
            ctrl_o.addr_sel = AddrSelIr;
            ctrl_o.wr       = 1'b1;
            ctrl_o.x_sel    = XSelAcc;
          end
          OpAdd, OpSub: begin
            ctrl_o.addr_sel = AddrSelIr;
            ctrl_o.rd       = 1'b1;
            ctrl_o.x_sel    = XSelAcc;
            ctrl_o.y_sel    = YSelData;
            ctrl_o.m        = (f_i == OpAdd) ? MAdd : MSub;
            ctrl_o.acc_en   = mem_ready_i;
          end
          OpJmp, OpJge, OpJne: begin
            // Jump target comes from IR[11:0] passed through the ALU.
            ctrl_o.y_sel = YSelIr;
            ctrl_o.m     = MPassY;
            if (f_i == OpJmp) begin
              ctrl_o.pc_en = 1'b1;
            end else if (f_i == OpJge) begin
              ctrl_o.pc_en = ~n_i;
            end else begin
              ctrl_o.pc_en = ~z_i;
            end
          end
          default: ; // STP and NOPs drive nothing
        endcase
      end
      StHalt: begin
        ctrl_o.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit top: FETCH/EXECUTE/HALT state register, completed-
// instruction counter and reset gating of enables/strobes around mu0_decode.
//   Clk, Reset      : clock, synchronous active-high reset
//   F, N, Z         : opcode and accumulator flags from the datapath
//   Mem_ready       : memory completes the current Rd/Wr this cycle
//   X_sel, Y_sel, Addr_sel, M : datapath mux selects and ALU op
//   PC_En, IR_En, Acc_En      : register load enables
//   Rd, Wr          : memory strobes
//   Halted          : high in HALT
//   Instr_count     : instructions completed since reset (wraps)
module mu0_control
  import mu0_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [3:0]         F,
  input  logic               N,
  input  logic               Z,
  input  logic               Mem_ready,
  output logic               X_sel,
  output logic               Y_sel,
  output logic               Addr_sel,
  output logic               PC_En,
  output logic               IR_En,
  output logic               Acc_En,
  output logic [1:0]         M,
  output logic               Rd,
  output logic               Wr,
  output logic               Halted,
  output logic [COUNT_W-1:0] Instr_count
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 exec_done;
  ctrl_t                ctrl;

  always_comb begin
    state_d   = state_q;
    exec_done = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (Mem_ready) state_d = StExecute;
      end
      StExecute: begin
        if (is_mem_op(F)) begin
          if (Mem_ready) begin
            state_d   = StFetch;
            exec_done = 1'b1;
          end
        end else if (F == OpStp) begin
          state_d   = StHalt;
          exec_done = 1'b1;
        end else begin
          // Jumps and NOPs complete in one cycle regardless of Mem_ready.
          state_d   = StFetch;
          exec_done = 1'b1;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (exec_done) count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  mu0_decode u_decode (
    .state_i     (state_q),
    .f_i         (F),
    .n_i         (N),
    .z_i         (Z),
    .mem_ready_i (Mem_ready),
    .ctrl_o      (ctrl)
  );

  // Enables and strobes are suppressed while Reset is held so nothing in the
  // datapath or memory is disturbed during the reset cycle.
  assign X_sel       = ctrl.x_sel;
  assign Y_sel       = ctrl.y_sel;
  assign Addr_sel    = ctrl.addr_sel;
  assign M           = ctrl.m;
  assign PC_En       = ctrl.pc_en  & ~Reset;
  assign IR_En       = ctrl.ir_en  & ~Reset;
  assign Acc_En      = ctrl.acc_en & ~Reset;
  assign Rd          = ctrl.rd     & ~Reset;
  assign Wr          = ctrl.wr     & ~Reset;
  assign Halted      = ctrl.halted & ~Reset;
  assign Instr_count = count_q;

endmodule

// File: tb/tb_mu0_control.sv
// Directed self-checking bench for mu0_control. A second instance with a
// 4-bit counter shares all inputs and is used for the wrap-around check.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] F = 4'd0;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic       Mem_ready = 1'b0;

  logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Halted;
  logic [1:0]  M;
  logic [15:0] Instr_count;

  logic        w_x_sel, w_y_sel, w_addr_sel, w_pc_en, w_ir_en, w_acc_en;
  logic        w_rd, w_wr, w_halted;
  logic [1:0]  w_m;
  logic [3:0]  w_count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mu0_control #(.COUNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_ready(Mem_ready),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .M(M),
    .Rd(Rd), .Wr(Wr), .Halted(Halted), .Instr_count(Instr_count)
  );

  mu0_control #(.COUNT_W(4)) dut_w (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_ready(Mem_ready),
    .X_sel(w_x_sel), .Y_sel(w_y_sel), .Addr_sel(w_addr_sel),
    .PC_En(w_pc_en), .IR_En(w_ir_en), .Acc_En(w_acc_en), .M(w_m),
    .Rd(w_rd), .Wr(w_wr), .Halted(w_halted), .Instr_count(w_count)
  );

  // {X_sel, Y_sel, Addr_sel, M[1:0], PC_En, IR_En, Acc_En, Rd, Wr, Halted}
  logic [10:0] obs;
  assign obs = {X_sel, Y_sel, Addr_sel, M, PC_En, IR_En, Acc_En, Rd, Wr, Halted};

  localparam logic [10:0] VFetchRdy  = 11'b100_10_110100;
  localparam logic [10:0] VFetchWait = 11'b100_10_000100;
  localparam logic [10:0] VFetchRst  = 11'b100_10_000000;
  localparam logic [10:0] VLdaRdy    = 11'b001_00_001100;
  localparam logic [10:0] VAddRdy    = 11'b001_01_001100;
  localparam logic [10:0] VAddWait   = 11'b001_01_000100;
  localparam logic [10:0] VSubRdy    = 11'b001_11_001100;
  localparam logic [10:0] VSta       = 11'b001_00_000010;
  localparam logic [10:0] VStaRst    = 11'b001_00_000000;
  localparam logic [10:0] VJmpTaken  = 11'b010_00_100000;
  localparam logic [10:0] VJmpNot    = 11'b010_00_000000;
  localparam logic [10:0] VNone      = 11'b000_00_000000;
  localparam logic [10:0] VHalt      = 11'b000_00_000001;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; F = 4'd0; Mem_ready = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (obs !== VFetchRst) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, VFetchRst);
    end
    checks++;
    if (Instr_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", Instr_count);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (obs !== VFetchRdy) begin
      errors++; $display("FAIL fetch_after_reset: got %b expected %b", obs, VFetchRdy);
    end
  endtask

  task automatic test_lda();
    do_reset();
    F = 4'd0; Mem_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (obs !== VLdaRdy) begin
      errors++; $display("FAIL lda_execute: got %b expected %b", obs, VLdaRdy);
    end
    tick();
    checks++;
    if (obs !== VFetchRdy || Instr_count !== 16'd1) begin
      errors++;
      $display("FAIL lda_complete: got %b cnt %0d expected %b cnt 1",
               obs, Instr_count, VFetchRdy);
    end
  endtask

  task automatic test_add_wait();
    do_reset();
    F = 4'd2; Mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== VFetchWait) begin
      errors++; $display("FAIL fetch_wait: got %b expected %b", obs, VFetchWait);
    end
    Mem_ready = 1'b1;
    tick();
    Mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== VAddWait) begin
        errors++; $display("FAIL add_wait_%0d: got %b expected %b", i, obs, VAddWait);
      end
      tick();
    end
    Mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== VAddRdy) begin
      errors++; $display("FAIL add_ready: got %b expected %b", obs, VAddRdy);
    end
    tick();
    checks++;
    if (obs !== VFetchRdy || Instr_count !== 16'd1) begin
      errors++;
      $display("FAIL add_complete: got %b cnt %0d expected %b cnt 1",
               obs, Instr_count, VFetchRdy);
    end
    F = 4'd3;
    tick();
    checks++;
    if (obs !== VSubRdy) begin
      errors++; $display("FAIL sub_execute: got %b expected %b", obs, VSubRdy);
    end
    tick();
    checks++;
    if (Instr_count !== 16'd2) begin
      errors++; $display("FAIL sub_count: got %0d expected 2", Instr_count);
    end
  endtask

  task automatic test_jumps();
    do_reset();
    Mem_ready = 1'b1; F = 4'd5; N = 1'b1;
    tick();
    checks++;
    if (obs !== VJmpNot) begin
      errors++; $display("FAIL jge_neg: got %b expected %b", obs, VJmpNot);
    end
    tick();
    N = 1'b0;
    tick();
    checks++;
    if (obs !== VJmpTaken) begin
      errors++; $display("FAIL jge_pos: got %b expected %b", obs, VJmpTaken);
    end
    tick();
    F = 4'd6; Z = 1'b1;
    tick();
    checks++;
    if (obs !== VJmpNot) begin
      errors++; $display("FAIL jne_zero: got %b expected %b", obs, VJmpNot);
    end
    Z = 1'b0;
    #1;
    checks++;
    if (obs !== VJmpTaken) begin
      errors++; $display("FAIL jne_nonzero: got %b expected %b", obs, VJmpTaken);
    end
    tick();
    // JMP completes even with Mem_ready low.
    F = 4'd4;
    tick();
    Mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== VJmpTaken) begin
      errors++; $display("FAIL jmp_exec: got %b expected %b", obs, VJmpTaken);
    end
    tick();
    checks++;
    if (obs !== VFetchWait || Instr_count !== 16'd4) begin
      errors++;
      $display("FAIL jmp_no_wait: got %b cnt %0d expected %b cnt 4",
               obs, Instr_count, VFetchWait);
    end
    // NOP opcode: nothing driven, one cycle.
    Mem_ready = 1'b1; F = 4'd11;
    tick();
    checks++;
    if (obs !== VNone) begin
      errors++; $display("FAIL nop_exec: got %b expected %b", obs, VNone);
    end
    tick();
    checks++;
    if (obs !== VFetchRdy || Instr_count !== 16'd5) begin
      errors++;
      $display("FAIL nop_complete: got %b cnt %0d expected %b cnt 5",
               obs, Instr_count, VFetchRdy);
    end
  endtask

  task automatic test_halt();
    do_reset();
    F = 4'd7; Mem_ready = 1'b1;
    tick();
    checks++;
    if (obs !== VNone) begin
      errors++; $display("FAIL stp_exec: got %b expected %b", obs, VNone);
    end
    tick();
    checks++;
    if (Instr_count !== 16'd1) begin
      errors++; $display("FAIL stp_count: got %0d expected 1", Instr_count);
    end
    for (int i = 0; i < 10; i++) begin
      Mem_ready = i[0];
      F = 4'(i);
      #1;
      checks++;
      if (obs !== VHalt) begin
        errors++; $display("FAIL halt_hold_%0d: got %b expected %b", i, obs, VHalt);
      end
      tick();
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== VNone) begin
      errors++; $display("FAIL halt_reset_gate: got %b expected %b", obs, VNone);
    end
    tick();
    Reset = 1'b0; Mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== VFetchRdy || Instr_count !== 16'd0) begin
      errors++;
      $display("FAIL halt_exit: got %b cnt %0d expected %b cnt 0",
               obs, Instr_count, VFetchRdy);
    end
  endtask

  task automatic test_sta_reset();
    do_reset();
    F = 4'd0; Mem_ready = 1'b1;
    tick(); tick();
    F = 4'd1;
    tick();
    Mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== VSta || Instr_count !== 16'd1) begin
      errors++;
      $display("FAIL sta_exec: got %b cnt %0d expected %b cnt 1", obs, Instr_count, VSta);
    end
    tick();
    checks++;
    if (obs !== VSta) begin
      errors++; $display("FAIL sta_hold: got %b expected %b", obs, VSta);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== VStaRst) begin
      errors++; $display("FAIL sta_reset_gate: got %b expected %b", obs, VStaRst);
    end
    tick();
    Reset = 1'b0; Mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== VFetchRdy || Instr_count !== 16'd0) begin
      errors++;
      $display("FAIL sta_reset_exit: got %b cnt %0d expected %b cnt 0",
               obs, Instr_count, VFetchRdy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    F = 4'd4; Mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); tick();
      if (i == 14) begin
        checks++;
        if (w_count !== 4'd15) begin
          errors++; $display("FAIL wrap_pre: got %0d expected 15", w_count);
        end
      end
    end
    checks++;
    if (w_count !== 4'd0) begin
      errors++; $display("FAIL wrap_zero: got %0d expected 0", w_count);
    end
    checks++;
    if (Instr_count !== 16'd16) begin
      errors++; $display("FAIL wide_count: got %0d expected 16", Instr_count);
    end
  endtask

  always @(negedge Clk) begin
    if (Rd === 1'b1 && Wr === 1'b1) begin
      errors++;
      $display("FAIL rd_wr_exclusive: got Rd=1 Wr=1 required not both");
    end
  end

  initial begin
    test_reset();
    test_lda();
    test_add_wait();
    test_jumps();
    test_halt();
    test_sta_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
